// File: rtl/led_uart_pkg.sv
// Shared constants, state encodings and the command decoder for the LED/UART board block.
package led_uart_pkg;

    localparam logic [7:0] CMD_REPLAY   = 8'h30;
    localparam logic [7:0] CMD_LED_BASE = 8'h31;
    localparam logic [7:0] CMD_LED_LAST = 8'h35;

    typedef enum logic [1:0] {
        UART_IDLE,
        UART_START,
        UART_DATA,
        UART_STOP
    } uart_state_e;

    typedef enum logic {
        MODE_IDLE,
        MODE_REPLAY
    } mode_e;

    // One-hot LED toggle mask for a command byte; zero for anything that is not '1'..'5'.
    function automatic logic [4:0] led_mask(input logic [7:0] cmd);
        logic [7:0] ofs;
        ofs      = cmd - CMD_LED_BASE;
        led_mask = 5'b00000;
        if (cmd >= CMD_LED_BASE && cmd <= CMD_LED_LAST) begin
            led_mask = 5'b00001 << ofs[2:0];
        end
    endfunction

endpackage

// File: rtl/uart_rx.sv
// 8N1 UART receiver: two-flop synchronizer, mid-bit sampling FSM, one-clock rx_valid pulse.
module uart_rx
    import led_uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 1250
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       rx_i,
    output logic       rx_valid_o,
    output logic [7:0] rx_byte_o
);

    localparam int              TW        = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [TW-1:0]   BIT_LAST  = TW'(CLKS_PER_BIT - 1);
    localparam logic [TW-1:0]   HALF_LAST = TW'(CLKS_PER_BIT / 2 - 1);

    logic          meta_q, sync_q, prev_q;
    uart_state_e   state_q, state_d;
    logic [TW-1:0] timer_q, timer_d;
    logic [2:0]    bit_q, bit_d;
    logic [7:0]    shift_q, shift_d;
    logic          valid_q, valid_d;

    always_comb begin
        // NOTE: every output of this block gets a default first, so no path can infer a latch.
        state_d = state_q;
        timer_d = timer_q + TW'(1);
        bit_d   = bit_q;
        shift_d = shift_q;
        valid_d = 1'b0;
        unique case (state_q)
            UART_IDLE: begin
                timer_d = '0;
                if (prev_q && !sync_q) state_d = UART_START;
            end
            UART_START: begin
                if (timer_q == HALF_LAST) begin
                    timer_d = '0;
                    bit_d   = '0;
                    state_d = sync_q ? UART_IDLE : UART_DATA;
                end
            end
            UART_DATA: begin
                if (timer_q == BIT_LAST) begin
                    timer_d = '0;
                    shift_d = {sync_q, shift_q[7:1]};
                    bit_d   = bit_q + 3'd1;
                    if (bit_q == 3'd7) state_d = UART_STOP;
                end
            end
            UART_STOP: begin
                if (timer_q == BIT_LAST) begin
                    timer_d = '0;
                    valid_d = sync_q;
                    state_d = UART_IDLE;
                end
            end
            default: state_d = UART_IDLE;
        endcase
    end

    // Synchronizer flops reset to the idle-high line level so release never fakes a start edge.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: sequential state uses non-blocking assignments so every flop sees pre-edge values.
        if (!rst_n) begin
            meta_q  <= 1'b1;
            sync_q  <= 1'b1;
            prev_q  <= 1'b1;
            state_q <= UART_IDLE;
            timer_q <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            valid_q <= 1'b0;
        end else begin
            meta_q  <= rx_i;
            sync_q  <= meta_q;
            prev_q  <= sync_q;
            state_q <= state_d;
            timer_q <= timer_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            valid_q <= valid_d;
        end
    end

    assign rx_valid_o = valid_q;
    assign rx_byte_o  = shift_q;

endmodule

// File: rtl/led_uart_top.sv
// LED toggle board block: UART commands toggle LEDs, are logged, and '0' replays the log on TX.
// Define UART_ECHO_EN to echo every byte received in idle mode back on TX.
module led_uart_top
    import led_uart_pkg::*;
#(
    parameter int CLK_FREQ     = 12000000,
    parameter int BAUD         = 9600,
    parameter int CLKS_PER_BIT = CLK_FREQ / BAUD,
    parameter int LOG_DEPTH    = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic RX,
    output logic TX,
    output logic LED1,
    output logic LED2,
    output logic LED3,
    output logic LED4,
    output logic LED5
);

    localparam int            TW       = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int            AW       = (LOG_DEPTH > 1) ? $clog2(LOG_DEPTH) : 1;
    localparam int            CW       = $clog2(LOG_DEPTH) + 1;
    localparam logic [TW-1:0] BIT_LAST = TW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] DEPTH_C  = CW'(LOG_DEPTH);

    logic       rx_valid;
    logic [7:0] rx_byte;

    uart_rx #(
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_rx (
        .clk        (clk),
        .rst_n      (rst_n),
        .rx_i       (RX),
        .rx_valid_o (rx_valid),
        .rx_byte_o  (rx_byte)
    );

    mode_e         mode_q, mode_d;
    logic [4:0]    leds_q, leds_d;
    logic [CW-1:0] count_q, count_d;
    logic [CW-1:0] idx_q, idx_d;
    logic          wait_q, wait_d;
    logic [7:0]    log_q [LOG_DEPTH];
    logic          log_we;

    logic          tx_load;
    logic [7:0]    tx_byte;
    uart_state_e   tx_state_q, tx_state_d;
    logic [TW-1:0] tx_timer_q, tx_timer_d;
    logic [2:0]    tx_bit_q, tx_bit_d;
    logic [7:0]    tx_shift_q, tx_shift_d;
    logic          tx_q, tx_d;
    logic          tx_done_q, tx_done_d;

    always_comb begin
        mode_d  = mode_q;
        leds_d  = leds_q;
        count_d = count_q;
        idx_d   = idx_q;
        wait_d  = wait_q;
        log_we  = 1'b0;
        tx_load = 1'b0;
        tx_byte = log_q[idx_q[AW-1:0]];
        unique case (mode_q)
            MODE_IDLE: begin
                if (rx_valid) begin
                    if (led_mask(rx_byte) != 5'b00000) begin
                        leds_d = leds_q ^ led_mask(rx_byte);
                        if (count_q < DEPTH_C) begin
                            log_we  = 1'b1;
                            count_d = count_q + CW'(1);
                        end
                    end else if (rx_byte == CMD_REPLAY && count_q != '0) begin
                        mode_d = MODE_REPLAY;
                        leds_d = '0;
                        idx_d  = '0;
                        wait_d = 1'b0;
                    end
`ifdef UART_ECHO_EN
                    if (tx_state_q == UART_IDLE) begin
                        tx_load = 1'b1;
                        tx_byte = rx_byte;
                    end
`endif
                end
            end
            MODE_REPLAY: begin
                // Only load when the serializer is idle, so the next tx_done belongs to this frame.
                if (wait_q) begin
                    if (tx_done_q) begin
                        wait_d = 1'b0;
                        idx_d  = idx_q + CW'(1);
                    end
                end else if (idx_q == count_q) begin
                    mode_d = MODE_IDLE;
                end else if (tx_state_q == UART_IDLE) begin
                    leds_d  = leds_q ^ led_mask(log_q[idx_q[AW-1:0]]);
                    tx_load = 1'b1;
                    wait_d  = 1'b1;
                end
            end
            default: mode_d = MODE_IDLE;
        endcase
    end

    always_comb begin
        tx_state_d = tx_state_q;
        tx_timer_d = tx_timer_q + TW'(1);
        tx_bit_d   = tx_bit_q;
        tx_shift_d = tx_shift_q;
        tx_d       = tx_q;
        tx_done_d  = 1'b0;
        unique case (tx_state_q)
            UART_IDLE: begin
                tx_timer_d = '0;
                tx_d       = 1'b1;
                if (tx_load) begin
                    tx_state_d = UART_START;
                    tx_shift_d = tx_byte;
                    tx_d       = 1'b0;
                end
            end
            UART_START: begin
                if (tx_timer_q == BIT_LAST) begin
                    tx_timer_d = '0;
                    tx_bit_d   = '0;
                    tx_d       = tx_shift_q[0];
                    tx_state_d = UART_DATA;
                end
            end
            UART_DATA: begin
                if (tx_timer_q == BIT_LAST) begin
                    tx_timer_d = '0;
                    tx_bit_d   = tx_bit_q + 3'd1;
                    if (tx_bit_q == 3'd7) begin
                        tx_d       = 1'b1;
                        tx_state_d = UART_STOP;
                    end else begin
                        tx_shift_d = {1'b0, tx_shift_q[7:1]};
                        tx_d       = tx_shift_q[1];
                    end
                end
            end
            UART_STOP: begin
                if (tx_timer_q == BIT_LAST) begin
                    tx_timer_d = '0;
                    tx_done_d  = 1'b1;
                    tx_state_d = UART_IDLE;
                end
            end
            default: tx_state_d = UART_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mode_q     <= MODE_IDLE;
            leds_q     <= '0;
            count_q    <= '0;
            idx_q      <= '0;
            wait_q     <= 1'b0;
            tx_state_q <= UART_IDLE;
            tx_timer_q <= '0;
            tx_bit_q   <= '0;
            tx_shift_q <= '0;
            tx_q       <= 1'b1;
            tx_done_q  <= 1'b0;
        end else begin
            mode_q     <= mode_d;
            leds_q     <= leds_d;
            count_q    <= count_d;
            idx_q      <= idx_d;
            wait_q     <= wait_d;
            tx_state_q <= tx_state_d;
            tx_timer_q <= tx_timer_d;
            tx_bit_q   <= tx_bit_d;
            tx_shift_q <= tx_shift_d;
            tx_q       <= tx_d;
            tx_done_q  <= tx_done_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: the log is a handful of flops, so it clears with the rest; a RAM log could skip
        // the reset because count gates every read.
        if (!rst_n) begin
            for (int i = 0; i < LOG_DEPTH; i++) log_q[i] <= '0;
        end else if (log_we) begin
            log_q[count_q[AW-1:0]] <= rx_byte;
        end
    end

    assign TX   = tx_q;
    assign LED1 = leds_q[0];
    assign LED2 = leds_q[1];
    assign LED3 = leds_q[2];
    assign LED4 = leds_q[3];
    assign LED5 = leds_q[4];

endmodule

// File: tb/tb_led_uart_top.sv
// Self-checking bench for led_uart_top: command table, corner sequences, and random commands
// scored against a queue-based model of the LED state and command log.
module tb_led_uart_top;

    localparam int CLK_FREQ = 1300000;
    localparam int BAUD     = 100000;
    localparam int CPB      = CLK_FREQ / BAUD;
    localparam int DEPTH    = 16;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    logic RX    = 1'b1;
    logic TX, LED1, LED2, LED3, LED4, LED5;
    logic [4:0] leds;

    assign leds = {LED5, LED4, LED3, LED2, LED1};

    always #5 clk = ~clk;

    led_uart_top #(
        .CLK_FREQ  (CLK_FREQ),
        .BAUD      (BAUD),
        .LOG_DEPTH (DEPTH)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .RX    (RX),
        .TX    (TX),
        .LED1  (LED1),
        .LED2  (LED2),
        .LED3  (LED3),
        .LED4  (LED4),
        .LED5  (LED5)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // ---------------- TX line decoder ----------------
    typedef struct {
        logic [7:0] data;
        logic [4:0] leds;
        logic       stop_ok;
    } frame_t;

    frame_t frames[$];
    int     tx_edges = 0;

    always @(TX) if (rst_n === 1'b1) tx_edges++;

    initial begin : tx_mon
        frame_t f;
        forever begin
            @(negedge TX);
            @(negedge clk);
            f.leds = leds;
            repeat (CPB / 2 - 1) @(negedge clk);
            if (TX !== 1'b0) continue;
            for (int i = 0; i < 8; i++) begin
                repeat (CPB) @(negedge clk);
                f.data[i] = TX;
            end
            repeat (CPB) @(negedge clk);
            f.stop_ok = TX;
            frames.push_back(f);
        end
    end

    // ---------------- reference model ----------------
    logic [4:0] model_leds;
    logic [7:0] model_log[$];

    function automatic logic [4:0] flip_of(input logic [7:0] b);
        int k;
        k = int'(b) - 'h31;
        if (k >= 0 && k < 5) return 5'(1 << k);
        return 5'b0;
    endfunction

    task automatic model_cmd(input logic [7:0] b);
        if (flip_of(b) != 5'b0) begin
            model_leds ^= flip_of(b);
            if (model_log.size() < DEPTH) model_log.push_back(b);
        end
    endtask

    // ---------------- stimulus helpers ----------------
    task automatic send_byte(input logic [7:0] b, input logic stop_bit);
        RX = 1'b0;
        repeat (CPB) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            RX = b[i];
            repeat (CPB) @(negedge clk);
        end
        RX = stop_bit;
        repeat (CPB) @(negedge clk);
        RX = 1'b1;
        repeat (CPB) @(negedge clk);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check("reset leds", leds, 5'b0);
        check("reset tx", TX, 1'b1);
        rst_n = 1'b1;
        model_leds = '0;
        model_log.delete();
        repeat (2) @(negedge clk);
    endtask

    // Waits for a replay of the whole model log and scores every frame and LED step.
    task automatic expect_replay(input string name, input int extra_bits);
        int         n;
        int         cyc;
        logic [4:0] cum;
        n   = model_log.size();
        cyc = 0;
        cum = '0;
        while (frames.size() < n && cyc < (10 * n + extra_bits) * CPB) begin
            @(negedge clk);
            cyc++;
        end
        check({name, " frame count"}, frames.size(), n);
        for (int i = 0; i < n; i++) begin
            cum ^= flip_of(model_log[i]);
            if (i < frames.size()) begin
                check($sformatf("%s frame %0d data", name, i), frames[i].data, model_log[i]);
                check($sformatf("%s frame %0d leds", name, i), frames[i].leds, cum);
                check($sformatf("%s frame %0d stop", name, i), frames[i].stop_ok, 1'b1);
            end
        end
        repeat (2 * CPB) @(negedge clk);
        check({name, " final leds"}, leds, cum);
        model_leds = cum;
    endtask

    task automatic do_cmd(input logic [7:0] b, input string name);
        frames.delete();
        send_byte(b, 1'b1);
        if (b == 8'h30 && model_log.size() > 0) begin
            expect_replay(name, 2);
        end else begin
            model_cmd(b);
            check(name, leds, model_leds);
            check({name, " tx quiet"}, frames.size(), 0);
        end
    endtask

    typedef struct {
        logic [7:0] data;
        logic       stop_bit;
        logic [4:0] exp_leds;
    } vec_t;

    vec_t vecs[$];

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : main
        model_leds = '0;

        vecs = '{
            '{8'h31, 1'b1, 5'b00001}, '{8'h32, 1'b1, 5'b00011}, '{8'h33, 1'b1, 5'b00111},
            '{8'h34, 1'b1, 5'b01111}, '{8'h35, 1'b1, 5'b11111}, '{8'h31, 1'b1, 5'b11110},
            '{8'h32, 1'b1, 5'b11100}, '{8'h33, 1'b1, 5'b11000}, '{8'h34, 1'b1, 5'b10000},
            '{8'h35, 1'b1, 5'b00000}, '{8'h41, 1'b1, 5'b00000}, '{8'h36, 1'b1, 5'b00000},
            '{8'h2F, 1'b1, 5'b00000}, '{8'h33, 1'b0, 5'b00000}
        };

        // Reset, then an idle line for 10 bit-periods.
        do_reset();
        repeat (10 * CPB) @(negedge clk);
        check("idle tx", TX, 1'b1);
        check("idle leds", leds, 5'b0);
        check("idle tx edges", tx_edges, 0);

        // Command table: two passes over '1'..'5', ignored bytes, a framing error.
        foreach (vecs[i]) begin
            send_byte(vecs[i].data, vecs[i].stop_bit);
            if (vecs[i].stop_bit) model_cmd(vecs[i].data);
            check($sformatf("table %0d leds", i), leds, vecs[i].exp_leds);
        end

        // Short start glitch, then a long low that ends as a framing error.
        RX = 1'b0;
        repeat (CPB / 2 - 2) @(negedge clk);
        RX = 1'b1;
        repeat (2 * CPB) @(negedge clk);
        check("glitch leds", leds, 5'b0);
        RX = 1'b0;
        repeat (12 * CPB) @(negedge clk);
        RX = 1'b1;
        repeat (2 * CPB) @(negedge clk);
        check("long low leds", leds, 5'b0);
        check("no tx after errors", tx_edges, 0);

        // Replay of ten logged commands, then confirm idle mode by toggling LED1.
        check("log size before replay", model_log.size(), 10);
        do_cmd(8'h30, "replay10");
        do_cmd(8'h31, "post replay toggle");

        // Reset in the middle of a replay discards the log.
        frames.delete();
        send_byte(8'h30, 1'b1);
        repeat (3 * CPB) @(negedge clk);
        do_reset();
        repeat (12 * CPB) @(negedge clk);
        frames.delete();
        begin
            int edges_before;
            edges_before = tx_edges;
            send_byte(8'h30, 1'b1);
            repeat (12 * CPB) @(negedge clk);
            check("empty log replay edges", tx_edges, edges_before);
            check("empty log leds", leds, 5'b0);
        end

        // Seventeen '1' commands: the last toggles but is not logged.
        for (int i = 0; i < 17; i++) do_cmd(8'h31, $sformatf("fill %0d", i));
        check("fill led1", LED1, 1'b1);
        frames.delete();
        send_byte(8'h30, 1'b1);
        send_byte(8'h32, 1'b1);
        expect_replay("replay16", 2);
        check("replay16 led1", LED1, 1'b0);
        do_cmd(8'h41, "ignored A");

        // Random commands scored against the model.
        do_reset();
        for (int i = 0; i < 30; i++) begin
            int         r;
            logic [7:0] b;
            r = $urandom_range(0, 9);
            if (r == 0)      b = 8'h30;
            else if (r < 8)  b = 8'h31 + 8'($urandom_range(0, 4));
            else             b = 8'($urandom_range(0, 255));
            do_cmd(b, $sformatf("rand %0d cmd 0x%0h", i, b));
        end
        frames.delete();
        send_byte(8'h30, 1'b1);
        if (model_log.size() > 0) expect_replay("rand final replay", 2);
        else check("rand final leds", leds, model_leds);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
